// File: rtl/ram_1wnr_clr.sv
// One-write / NUM_RD-read RAM with byte-enable writes, write-first bypass and a
// hardware clear sequencer that leaves a known memory image after reset or clr_req.
module ram_1wnr_clr #(
  parameter int                WIDTH          = 8,
  parameter int                DEPTH          = 8,
  parameter int                NUM_RD         = 2,
  parameter int                BYTE_W         = 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0]  CLEAR_VAL      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [DEPTH-1:0]          waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [WIDTH/BYTE_W-1:0]   wbe,
  input  logic [NUM_RD*DEPTH-1:0]   raddr,
  output logic [NUM_RD*WIDTH-1:0]   rdata,
  input  logic                      clr_req,
  output logic                      busy
);

  localparam int             NBE   = WIDTH / BYTE_W;
  localparam int             WORDS = 2 ** DEPTH;
  localparam logic [DEPTH:0] LAST  = (DEPTH + 1)'(WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [DEPTH:0]   clr_cnt, clr_cnt_nxt;
  logic [WIDTH-1:0] mem [WORDS];
  logic             wr_en;
  logic [WIDTH-1:0] wr_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // clr_req while already clearing is ignored so the sweep never restarts
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = (state == IDLE) && we && !clr_req;

  always_comb begin
    wr_word = mem[waddr];
    for (int b = 0; b < NBE; b++) begin
      if (wbe[b]) wr_word[b*BYTE_W +: BYTE_W] = wdata[b*BYTE_W +: BYTE_W];
    end
  end

  // Storage has no reset; writes are held off while rst is asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)       mem[clr_cnt[DEPTH-1:0]] <= CLEAR_VAL;
      else if (wr_en) mem[waddr]              <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (busy)
          rdata[i*WIDTH +: WIDTH] <= CLEAR_VAL;
        else if (wr_en && (raddr[i*DEPTH +: DEPTH] == waddr))
          rdata[i*WIDTH +: WIDTH] <= wr_word;
        else
          rdata[i*WIDTH +: WIDTH] <= mem[raddr[i*DEPTH +: DEPTH]];
      end
    end
  end

endmodule

// File: tb/tb_ram_1wnr_clr.sv
// Self-checking bench for ram_1wnr_clr: directed vector table, clear/reset
// corner sequences and a long random run against a behavioural memory model.
module tb_ram_1wnr_clr;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int NUM_RD = 4;
  localparam int BYTE_W = 8;
  localparam int NBE    = WIDTH / BYTE_W;
  localparam int WORDS  = 2 ** DEPTH;
  localparam logic [WIDTH-1:0] CLEAR_VAL = '0;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     we = 1'b0;
  logic [DEPTH-1:0]         waddr = '0;
  logic [WIDTH-1:0]         wdata = '0;
  logic [NBE-1:0]           wbe = '0;
  logic [NUM_RD*DEPTH-1:0]  raddr = '0;
  logic [NUM_RD*WIDTH-1:0]  rdata;
  logic                     clr_req = 1'b0;
  logic                     busy;

  ram_1wnr_clr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYTE_W(BYTE_W),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RD*WIDTH-1:0] rd;
    logic                    bsy;
  } exp_t;

  typedef struct {
    logic             w;
    logic [DEPTH-1:0] wa;
    logic [WIDTH-1:0] wd;
    logic [NBE-1:0]   be;
    logic [DEPTH-1:0] ra0;
    logic [DEPTH-1:0] ra1;
    logic [WIDTH-1:0] exp0;
    logic [WIDTH-1:0] exp1;
  } vec_t;

  exp_t             sb_q [$];
  logic [WIDTH-1:0] model_mem [WORDS];
  int               clr_left = 0;
  int               checks = 0;
  int               errors = 0;
  vec_t             tbl [9];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no entry, expected one at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < NUM_RD; i++)
        check_val($sformatf("rdata[%0d]", i), 64'(rdata[i*WIDTH +: WIDTH]), 64'(e.rd[i*WIDTH +: WIDTH]));
      check_val("busy", 64'(busy), 64'(e.bsy));
    end
  endtask

  // Drives one cycle, predicts the post-edge outputs, advances the model and checks
  task automatic apply_stimulus(input logic w, input logic [DEPTH-1:0] wa, input logic [WIDTH-1:0] wd,
                                input logic [NBE-1:0] be, input logic [NUM_RD*DEPTH-1:0] ra, input logic cr);
    exp_t             e;
    logic [WIDTH-1:0] merged;
    logic [DEPTH-1:0] a;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; wbe = be; raddr = ra; clr_req = cr;
    merged = model_mem[wa];
    for (int b = 0; b < NBE; b++)
      if (be[b]) merged[b*BYTE_W +: BYTE_W] = wd[b*BYTE_W +: BYTE_W];
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*DEPTH +: DEPTH];
      if (clr_left > 0)          e.rd[i*WIDTH +: WIDTH] = CLEAR_VAL;
      else if (w && !cr && a == wa) e.rd[i*WIDTH +: WIDTH] = merged;
      else                       e.rd[i*WIDTH +: WIDTH] = model_mem[a];
    end
    if (clr_left > 0) begin
      model_mem[WORDS - clr_left] = CLEAR_VAL;
      clr_left--;
    end else if (cr) begin
      clr_left = WORDS;
    end else if (w) begin
      model_mem[wa] = merged;
    end
    e.bsy = (clr_left > 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  function automatic logic [NUM_RD*DEPTH-1:0] rand_ra();
    logic [DEPTH-1:0] base, step;
    logic [NUM_RD*DEPTH-1:0] r;
    base = DEPTH'($urandom_range(0, WORDS - 1));
    step = DEPTH'(2 * $urandom_range(0, 7) + 1);
    for (int i = 0; i < NUM_RD; i++) r[i*DEPTH +: DEPTH] = base + DEPTH'(i) * step;
    return r;
  endfunction

  // Async reset: outputs must drop before any clock edge
  task automatic reset_dut();
    @(negedge clk);
    we = 1'b0; clr_req = 1'b0; wbe = '0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_RD; i++)
      check_val($sformatf("rst_rdata[%0d]", i), 64'(rdata[i*WIDTH +: WIDTH]), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(1));
    clr_left = WORDS;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic count_busy(input string name, input int cr_at, input int we_at);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      apply_stimulus(n == we_at, DEPTH'(6), 16'hFFFF, 2'b11, rand_ra(), n == cr_at);
      n++;
    end
    check_val(name, 64'(n), 64'(WORDS));
  endtask

  task automatic read_all();
    logic [NUM_RD*DEPTH-1:0] r;
    for (int k = 0; k < WORDS / NUM_RD; k++) begin
      for (int i = 0; i < NUM_RD; i++) r[i*DEPTH +: DEPTH] = DEPTH'(k * NUM_RD + i);
      apply_stimulus(1'b0, '0, '0, '0, r, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd5,  16'hABCD, 2'b11, 4'd5,  4'd4, 16'hABCD, 16'h0000};
    tbl[1] = '{1'b1, 4'd5,  16'h1234, 2'b01, 4'd5,  4'd5, 16'hAB34, 16'hAB34};
    tbl[2] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd5,  4'd5, 16'hAB34, 16'hAB34};
    tbl[3] = '{1'b1, 4'd4,  16'hBEEF, 2'b10, 4'd4,  4'd5, 16'hBE00, 16'hAB34};
    tbl[4] = '{1'b1, 4'd3,  16'h005A, 2'b11, 4'd3,  4'd4, 16'h005A, 16'hBE00};
    tbl[5] = '{1'b1, 4'd3,  16'hFFFF, 2'b00, 4'd3,  4'd3, 16'h005A, 16'h005A};
    tbl[6] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd3,  4'd4, 16'h005A, 16'hBE00};
    tbl[7] = '{1'b1, 4'd15, 16'hC0DE, 2'b11, 4'd15, 4'd0, 16'hC0DE, 16'h0000};
    tbl[8] = '{1'b0, 4'd0,  16'h0000, 2'b00, 4'd15, 4'd5, 16'hC0DE, 16'hAB34};
    for (int a = 0; a < WORDS; a++) model_mem[a] = 16'hDEAD;

    reset_dut();
    count_busy("busy_after_reset", -1, -1);
    read_all();

    for (int t = 0; t < 9; t++) begin
      apply_stimulus(tbl[t].w, tbl[t].wa, tbl[t].wd, tbl[t].be,
                     {tbl[t].ra0, tbl[t].ra1, tbl[t].ra1, tbl[t].ra0}, 1'b0);
      check_val($sformatf("vec%0d_port0", t), 64'(rdata[0*WIDTH +: WIDTH]), 64'(tbl[t].exp0));
      check_val($sformatf("vec%0d_port1", t), 64'(rdata[1*WIDTH +: WIDTH]), 64'(tbl[t].exp1));
      check_val($sformatf("vec%0d_port2", t), 64'(rdata[2*WIDTH +: WIDTH]), 64'(tbl[t].exp1));
      check_val($sformatf("vec%0d_port3", t), 64'(rdata[3*WIDTH +: WIDTH]), 64'(tbl[t].exp0));
    end

    // clr_req with a write in the same cycle, then clr_req and we mid-clear
    apply_stimulus(1'b1, 4'd6, 16'h7777, 2'b11, {4'd6, 4'd6, 4'd6, 4'd6}, 1'b1);
    check_val("clr_write_dropped", 64'(rdata[WIDTH-1:0]), 64'(0));
    check_val("clr_busy_next", 64'(busy), 64'(1));
    count_busy("busy_clr_restart_ignored", 4, 7);
    read_all();

    // Async reset while idle with nonzero read data
    apply_stimulus(1'b1, 4'd9, 16'h1357, 2'b11, {4'd9, 4'd9, 4'd9, 4'd9}, 1'b0);
    reset_dut();
    count_busy("busy_after_idle_reset", -1, -1);

    // Reset aborting a clear at clr_cnt=7
    apply_stimulus(1'b1, 4'd12, 16'h2468, 2'b11, rand_ra(), 1'b0);
    apply_stimulus(1'b0, '0, '0, '0, rand_ra(), 1'b1);
    for (int k = 0; k < 7; k++) apply_stimulus(1'b0, '0, '0, '0, rand_ra(), 1'b0);
    reset_dut();
    count_busy("busy_after_midclear_reset", -1, -1);
    read_all();

    for (int c = 0; c < 10000; c++) begin
      apply_stimulus(1'($urandom_range(0, 1)), DEPTH'($urandom_range(0, WORDS - 1)),
                     WIDTH'($urandom), NBE'($urandom_range(0, 3)), rand_ra(),
                     $urandom_range(0, 999) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
